// File: rtl/inst_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder:
// format codes, opcodes, immediate range limits and the FIFO entry layout.
package enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  // Byte-unit immediate limits; B and J upper bounds are the largest even values
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -1048576;
  localparam int IMMJ_MAX  = 1048574;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } enc_entry_t;

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle between an instruction producer (master)
// and the encoder (slave), including the address-load side channel.
interface inst_encoder_if #(
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [4:0]       in_rd;
  logic [31:0]      in_imm;
  logic             addr_load;
  logic [31:0]      addr_load_val;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [31:0]      out_addr;
  logic             out_err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rs1, in_rs2, in_rd, in_imm, addr_load, addr_load_val, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rs1, in_rs2, in_rd, in_imm, addr_load, addr_load_val, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational field packer: (format, fields, immediate) -> 32-bit word plus
// a range/alignment error flag. Out-of-range immediates still pack their low bits.
module inst_pack
  import enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  logic signed [31:0] imm_s;
  assign imm_s = $signed(imm);

  always_comb begin
    inst = '0;
    err  = 1'b0;
    case (fmt)
      FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        err  = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
      end
      FMT_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
      end
      FMT_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = (imm_s < IMMB_MIN) || (imm_s > IMMB_MAX) || imm[0];
      end
      FMT_U: begin
        inst = {imm[31:12], rd, opcode};
        err  = (imm[11:0] != 12'h000);
      end
      FMT_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = (imm_s < IMMJ_MIN) || (imm_s > IMMJ_MAX) || imm[0];
      end
      default: begin
        inst = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Sequential RV32I encoder: packs each accepted request, tags it with the
// running word address and buffers up to two results in a small FIFO.
module inst_encoder
  import enc_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          ERR_W     = 8
) (
  input logic           clk,
  input logic           rst,
  inst_encoder_if.slave bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  enc_entry_t       mem [2];
  enc_entry_t       head;
  enc_entry_t       new_entry;
  logic [31:0]      addr_cnt;
  logic [31:0]      tag_addr;
  logic [ERR_W-1:0] err_cnt_q;
  logic [31:0]      pack_inst;
  logic             pack_err;
  logic             push;
  logic             pop;

  inst_pack u_pack (
    .fmt    (bus.in_fmt),
    .opcode (bus.in_opcode),
    .funct3 (bus.in_funct3),
    .funct7 (bus.in_funct7),
    .rs1    (bus.in_rs1),
    .rs2    (bus.in_rs2),
    .rd     (bus.in_rd),
    .imm    (bus.in_imm),
    .inst   (pack_inst),
    .err    (pack_err)
  );

  assign bus.in_ready  = (count != ST_FULL);
  assign bus.out_valid = (count != ST_EMPTY);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // A same-cycle load takes priority so the pushed entry is tagged with the loaded address
  assign tag_addr  = bus.addr_load ? {bus.addr_load_val[31:2], 2'b00} : addr_cnt;
  assign new_entry = '{inst: pack_inst, addr: tag_addr, err: pack_err};

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= ST_EMPTY;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      addr_cnt  <= ADDR_BASE;
      err_cnt_q <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      addr_cnt <= push ? tag_addr + 32'd4 : tag_addr;
      if (push && pack_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= new_entry;
  end

  // Outputs read as zero while empty so stale entries never leak out
  assign head         = mem[rd_ptr];
  assign bus.out_inst = bus.out_valid ? head.inst : 32'h0;
  assign bus.out_addr = bus.out_valid ? head.addr : 32'h0;
  assign bus.out_err  = bus.out_valid ? head.err  : 1'b0;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder: encodings, error flags,
// backpressure, address load/wrap and mid-stream reset.
module tb_inst_encoder;
  import enc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  inst_encoder_if #(.ERR_W(8)) bus ();

  inst_encoder #(.ADDR_BASE(32'h0000_0000), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setFields(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] imm);
    bus.in_fmt = fmt; bus.in_opcode = op; bus.in_funct3 = f3; bus.in_funct7 = f7;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_imm = imm;
  endtask

  // Called at a negedge with fields already set; pushes one request
  task automatic applyStimulus(input string tag, input logic doLoad, input logic [31:0] loadVal);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.addr_load = doLoad;
    bus.addr_load_val = loadVal;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) checkOutput({tag, "_push_timeout"}, 32'd0, 32'd1);
    else @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.addr_load = 1'b0;
  endtask

  task automatic expectHead(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                            input logic err);
    int n = 0;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_inst"}, bus.out_inst, inst);
    checkOutput({tag, "_addr"}, bus.out_addr, addr);
    checkOutput({tag, "_err"}, 32'(bus.out_err), 32'(err));
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.addr_load = 1'b0; bus.addr_load_val = '0; bus.out_ready = 1'b0;
    setFields(3'd0, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_inst", bus.out_inst, 32'h0);
    checkOutput("rst_out_addr", bus.out_addr, 32'h0);
    checkOutput("rst_out_err", 32'(bus.out_err), 32'd0);
    checkOutput("rst_err_cnt", 32'(bus.err_cnt), 32'd0);

    setFields(FMT_I, OP_IMM, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
    applyStimulus("addi", 1'b0, 32'h0);
    expectHead("addi", 32'h00500093, 32'h0, 1'b0);

    setFields(FMT_S, OP_STORE, 3'd2, 7'h0, 5'd1, 5'd2, 5'd0, 32'd8);
    applyStimulus("sw", 1'b0, 32'h0);
    expectHead("sw", 32'h0020A423, 32'h4, 1'b0);

    setFields(FMT_B, OP_BRANCH, 3'd0, 7'h0, 5'd1, 5'd2, 5'd0, -32'sd4);
    applyStimulus("beq", 1'b0, 32'h0);
    expectHead("beq", 32'hFE208EE3, 32'h8, 1'b0);

    setFields(FMT_U, OP_LUI, 3'd0, 7'h0, 5'd0, 5'd0, 5'd5, 32'h12345000);
    applyStimulus("lui", 1'b0, 32'h0);
    expectHead("lui", 32'h123452B7, 32'hC, 1'b0);

    setFields(FMT_J, OP_JAL, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd2048);
    applyStimulus("jal", 1'b0, 32'h0);
    expectHead("jal", 32'h001000EF, 32'h10, 1'b0);

    setFields(FMT_R, OP_REG, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'h0);
    applyStimulus("sub", 1'b0, 32'h0);
    expectHead("sub", 32'h404182B3, 32'h14, 1'b0);

    setFields(FMT_B, OP_BRANCH, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd3);
    applyStimulus("b_odd", 1'b0, 32'h0);
    expectHead("b_odd", 32'h00000163, 32'h18, 1'b1);
    checkOutput("b_odd_errcnt", 32'(bus.err_cnt), 32'd1);

    setFields(3'd7, OP_IMM, 3'd0, 7'h0, 5'd1, 5'd1, 5'd1, 32'd0);
    applyStimulus("fmt7", 1'b0, 32'h0);
    expectHead("fmt7", 32'h0, 32'h1C, 1'b1);
    checkOutput("fmt7_errcnt", 32'(bus.err_cnt), 32'd2);

    setFields(FMT_I, OP_IMM, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd2048);
    applyStimulus("i_range", 1'b0, 32'h0);
    expectHead("i_range", 32'h80000013, 32'h20, 1'b1);
    checkOutput("i_range_errcnt", 32'(bus.err_cnt), 32'd3);

    setFields(FMT_I, OP_IMM, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, -32'sd2048);
    applyStimulus("i_min", 1'b0, 32'h0);
    expectHead("i_min", 32'h80000013, 32'h24, 1'b0);

    // Backpressure: fill both entries, third request must stall
    doReset();
    checkOutput("bp_errcnt_cleared", 32'(bus.err_cnt), 32'd0);
    setFields(FMT_I, OP_IMM, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd1);
    applyStimulus("bp_a", 1'b0, 32'h0);
    checkOutput("bp_ready_after_1", 32'(bus.in_ready), 32'd1);
    setFields(FMT_I, OP_IMM, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd2);
    applyStimulus("bp_b", 1'b0, 32'h0);
    checkOutput("bp_ready_after_2", 32'(bus.in_ready), 32'd0);
    setFields(FMT_I, OP_IMM, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd3);
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("bp_stalled", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_head_a_inst", bus.out_inst, 32'h00100093);
    checkOutput("bp_head_a_addr", bus.out_addr, 32'h0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_head_b_inst", bus.out_inst, 32'h00200093);
    checkOutput("bp_head_b_addr", bus.out_addr, 32'h4);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("bp_pushpop_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bp_head_c_inst", bus.out_inst, 32'h00300093);
    checkOutput("bp_head_c_addr", bus.out_addr, 32'h8);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);

    // Address load with simultaneous push, then wrap past the top
    setFields(FMT_U, OP_AUIPC, 3'd0, 7'h0, 5'd0, 5'd0, 5'd2, 32'h0);
    applyStimulus("wrap_a", 1'b1, 32'hFFFF_FFFE);
    expectHead("wrap_a", 32'h00000117, 32'hFFFF_FFFC, 1'b0);
    applyStimulus("wrap_b", 1'b0, 32'h0);
    expectHead("wrap_b", 32'h00000117, 32'h0, 1'b0);

    bus.addr_load = 1'b1;
    bus.addr_load_val = 32'h0000_0103;
    @(posedge clk);
    @(negedge clk);
    bus.addr_load = 1'b0;
    applyStimulus("load_only", 1'b0, 32'h0);
    expectHead("load_only", 32'h00000117, 32'h100, 1'b0);

    // Mid-stream reset with two entries buffered; concurrent load must be ignored
    setFields(3'd6, OP_IMM, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    applyStimulus("mid_a", 1'b0, 32'h0);
    applyStimulus("mid_b", 1'b0, 32'h0);
    checkOutput("mid_full", 32'(bus.in_ready), 32'd0);
    checkOutput("mid_errcnt", 32'(bus.err_cnt), 32'd2);
    rst = 1'b1;
    bus.addr_load = 1'b1;
    bus.addr_load_val = 32'h0000_0500;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.addr_load = 1'b0;
    checkOutput("mid_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("mid_errcnt_clr", 32'(bus.err_cnt), 32'd0);
    setFields(FMT_I, OP_IMM, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
    applyStimulus("mid_after", 1'b0, 32'h0);
    expectHead("mid_after", 32'h00500093, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got hang expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
